// File: rtl/dff_debounce_edge.sv
// rtl/dff_debounce_edge.sv - synchronizer, debouncer, edge pulses and saturating edge counter
//
// Conditions a raw asynchronous level before downstream sequential logic samples it.
// Optional glitch counter is enabled by defining DFF_DEBOUNCE_GLITCH_CNT_EN; when the
// macro is undefined glitch_cnt is tied to zero and no glitch logic exists.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   d_in       raw asynchronous level
//   cnt_clr    synchronous clear of edge_cnt, cnt_sat and glitch_cnt
//   q_stable   debounced, synchronized level
//   rise_pulse one-cycle strobe on q_stable 0->1
//   fall_pulse one-cycle strobe on q_stable 1->0
//   edge_cnt   saturating count of q_stable rising edges
//   cnt_sat    high while edge_cnt is all-ones
//   glitch_cnt saturating count of rejected glitches (zero when feature disabled)

module dff_debounce_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_in,
    input  logic             cnt_clr,
    output logic             q_stable,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_sat,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   d_sync;
    logic [DB_W-1:0]        db_cnt;
    logic [DB_W-1:0]        db_next;
    logic                   q_next;
    logic                   rise_next;
    logic                   fall_next;
    logic [CNT_W-1:0]       edge_next;

    assign d_sync = sync_q[SYNC_STAGES-1];

    // Plain shift chain: no logic between stages so each flop has a full
    // cycle to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
        end
    end

    // Counter tracks how many consecutive cycles d_sync has disagreed with
    // q_stable; the level is accepted on the DEBOUNCE_CYCLES-th disagreement.
    always_comb begin
        q_next  = q_stable;
        db_next = db_cnt;
        if (d_sync == q_stable) begin
            db_next = '0;
        end else if (db_cnt == DB_LAST) begin
            q_next  = d_sync;
            db_next = '0;
        end else begin
            db_next = db_cnt + 1'b1;
        end
    end

    assign rise_next = q_next & ~q_stable;
    assign fall_next = ~q_next & q_stable;

    // Clear wins over a coincident rising update.
    always_comb begin
        edge_next = edge_cnt;
        if (cnt_clr) begin
            edge_next = '0;
        end else if (rise_next && !(&edge_cnt)) begin
            edge_next = edge_cnt + 1'b1;
        end
    end

    // Pulses come from the next-state so they line up with the cycle in
    // which q_stable shows its new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt     <= '0;
            q_stable   <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            edge_cnt   <= '0;
            cnt_sat    <= 1'b0;
        end else begin
            db_cnt     <= db_next;
            q_stable   <= q_next;
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
            edge_cnt   <= edge_next;
            cnt_sat    <= &edge_next;
        end
    end

`ifdef DFF_DEBOUNCE_GLITCH_CNT_EN
    // A glitch is a partial disagreement run that ends with d_sync falling
    // back to the current stable level.
    logic glitch_evt;

    assign glitch_evt = (d_sync == q_stable) && (db_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (cnt_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_evt && !(&glitch_cnt)) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`else
    assign glitch_cnt = '0;
`endif

endmodule
